mult_issue_queue: RTL and testbench

MULT_ISSUE_QUEUE -- requirements
Module: mult_issue_queue

---
 rtl/mult_issue_queue_pkg.sv | 35 +++
 rtl/mult_iq_entry.sv | 41 ++++
 rtl/mult_issue_queue.sv | 106 ++++++++++
 tb/tb_mult_issue_queue.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mult_issue_queue_pkg.sv
// Shared types for the multiply issue queue: CDB snoop bus, execute-FIFO payload
// and the per-slot entry record.
package mult_issue_queue_pkg;

  localparam int TAG_W         = 6;
  localparam int MULT_IQ_DEPTH = 4;

  typedef struct packed {
    logic [TAG_W-1:0] rd_tag;
    logic [31:0]      rs1_data;
    logic [31:0]      rs2_data;
  } common_fifo_data;

  typedef struct packed {
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [31:0]      cdb_result;
  } cdb_bfm;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] rd_tag;
    logic [31:0]      rs1_data;
    logic [TAG_W-1:0] rs1_tag;
    logic             rs1_valid;
    logic [31:0]      rs2_data;
    logic [TAG_W-1:0] rs2_tag;
    logic             rs2_valid;
  } mult_iq_entry_t;

  function automatic logic entry_ready(input mult_iq_entry_t e);
    return e.valid & e.rs1_valid & e.rs2_valid;
  endfunction

endpackage

// File: rtl/mult_iq_entry.sv
// One issue-queue slot: registers whatever the top routes into it (held, shifted
// or freshly dispatched) after applying the CDB snoop to that incoming value.
module mult_iq_entry
  import mult_issue_queue_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  mult_iq_entry_t src,
  input  cdb_bfm         cdb,
  output mult_iq_entry_t entry,
  output logic           ready
);

  mult_iq_entry_t entry_reg, entry_next;

  // Snooping the routed source (not the old contents) keeps captures correct across shifts.
  always_comb begin
    entry_next = src;
    if (src.valid && cdb.cdb_valid) begin
      if (!src.rs1_valid && src.rs1_tag == cdb.cdb_tag) begin
        entry_next.rs1_data  = cdb.cdb_result;
        entry_next.rs1_valid = 1'b1;
      end
      if (!src.rs2_valid && src.rs2_tag == cdb.cdb_tag) begin
        entry_next.rs2_data  = cdb.cdb_result;
        entry_next.rs2_valid = 1'b1;
      end
    end
    if (flush) entry_next.valid = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) entry_reg <= '0;
    else     entry_reg <= entry_next;
  end

  assign entry = entry_reg;
  assign ready = entry_ready(entry_reg);

endmodule

// File: rtl/mult_issue_queue.sv
// Age-ordered, compacting multiply issue queue: oldest-ready select, shift-down on
// issue, append on dispatch, CDB snoop with same-cycle dispatch bypass.
module mult_issue_queue
  import mult_issue_queue_pkg::*;
#(
  parameter int DEPTH = MULT_IQ_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             dispatch_en,
  input  logic [TAG_W-1:0] dispatch_rd_tag,
  input  logic [31:0]      dispatch_rs1_data,
  input  logic [31:0]      dispatch_rs2_data,
  input  logic [TAG_W-1:0] dispatch_rs1_tag,
  input  logic [TAG_W-1:0] dispatch_rs2_tag,
  input  logic             dispatch_rs1_valid,
  input  logic             dispatch_rs2_valid,
  input  cdb_bfm           cdb,
  input  logic             issue_granted,
  output logic             mult_ready,
  output common_fifo_data  mult_exec_fifo_data,
  output logic             queue_full,
  output logic             queue_empty
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SEL_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  mult_iq_entry_t   slots [DEPTH];
  mult_iq_entry_t   src   [DEPTH];
  logic [DEPTH-1:0] ready_vec;
  logic [CNT_W-1:0] count_reg, count_next, write_pos;
  logic [SEL_W-1:0] sel;
  logic             do_issue, do_dispatch;
  mult_iq_entry_t   new_entry;

  always_comb begin
    sel = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ready_vec[i]) sel = SEL_W'(i);
    end
  end

  assign mult_ready  = |ready_vec;
  assign queue_full  = (count_reg == CNT_W'(DEPTH));
  assign queue_empty = (count_reg == '0);
  assign do_issue    = issue_granted & mult_ready;
  assign do_dispatch = dispatch_en & ~queue_full;
  // New entry lands right after the survivors of this cycle's compaction.
  assign write_pos   = count_reg - CNT_W'(do_issue);

  always_comb begin
    new_entry           = '0;
    new_entry.valid     = 1'b1;
    new_entry.rd_tag    = dispatch_rd_tag;
    new_entry.rs1_data  = dispatch_rs1_data;
    new_entry.rs1_tag   = dispatch_rs1_tag;
    new_entry.rs1_valid = dispatch_rs1_valid;
    new_entry.rs2_data  = dispatch_rs2_data;
    new_entry.rs2_tag   = dispatch_rs2_tag;
    new_entry.rs2_valid = dispatch_rs2_valid;
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      mult_iq_entry_t shifted;
      logic           shift_here;

      assign shift_here = do_issue && (sel <= SEL_W'(gi));
      if (gi == DEPTH - 1) begin : g_top
        assign shifted = shift_here ? mult_iq_entry_t'('0) : slots[gi];
      end else begin : g_mid
        assign shifted = shift_here ? slots[gi+1] : slots[gi];
      end
      assign src[gi] = (do_dispatch && write_pos == CNT_W'(gi)) ? new_entry : shifted;

      mult_iq_entry u_entry (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .src   (src[gi]),
        .cdb   (cdb),
        .entry (slots[gi]),
        .ready (ready_vec[gi])
      );
    end
  endgenerate

  assign count_next = count_reg + CNT_W'(do_dispatch) - CNT_W'(do_issue);

  always_ff @(posedge clk) begin
    if (rst || flush) count_reg <= '0;
    else              count_reg <= count_next;
  end

  always_comb begin
    mult_exec_fifo_data = '0;
    if (mult_ready) begin
      mult_exec_fifo_data.rd_tag   = slots[sel].rd_tag;
      mult_exec_fifo_data.rs1_data = slots[sel].rs1_data;
      mult_exec_fifo_data.rs2_data = slots[sel].rs2_data;
    end
  end

endmodule

// File: tb/tb_mult_issue_queue.sv
// Scoreboard bench: the driver advances a queue-based reference model each edge and
// pushes the expected outputs; a monitor pops and compares them half a cycle later.
module tb_mult_issue_queue;
  import mult_issue_queue_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, flush, dispatch_en, issue_granted;
  logic [TAG_W-1:0] dispatch_rd_tag, dispatch_rs1_tag, dispatch_rs2_tag;
  logic [31:0]      dispatch_rs1_data, dispatch_rs2_data;
  logic             dispatch_rs1_valid, dispatch_rs2_valid;
  cdb_bfm           cdb;
  logic             mult_ready, queue_full, queue_empty;
  common_fifo_data  mult_exec_fifo_data;

  mult_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .flush               (flush),
    .dispatch_en         (dispatch_en),
    .dispatch_rd_tag     (dispatch_rd_tag),
    .dispatch_rs1_data   (dispatch_rs1_data),
    .dispatch_rs2_data   (dispatch_rs2_data),
    .dispatch_rs1_tag    (dispatch_rs1_tag),
    .dispatch_rs2_tag    (dispatch_rs2_tag),
    .dispatch_rs1_valid  (dispatch_rs1_valid),
    .dispatch_rs2_valid  (dispatch_rs2_valid),
    .cdb                 (cdb),
    .issue_granted       (issue_granted),
    .mult_ready          (mult_ready),
    .mult_exec_fifo_data (mult_exec_fifo_data),
    .queue_full          (queue_full),
    .queue_empty         (queue_empty)
  );

  typedef struct {
    int unsigned tag;
    logic [31:0] d1, d2;
    int unsigned t1, t2;
    bit          v1, v2;
  } m_entry_t;

  typedef struct {
    bit              rdy;
    common_fifo_data data;
    bit              full;
    bit              empty;
  } exp_t;

  m_entry_t mq[$];
  exp_t     exp_q[$];
  int       checks = 0;
  int       passes = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, got, want);
  endtask

  // Reference model: list of in-flight ops, oldest first.
  task automatic model_update();
    int       iss;
    bit       full;
    m_entry_t e;
    iss  = -1;
    full = (mq.size() == DEPTH);
    if (rst || flush) begin
      mq.delete();
    end else begin
      for (int i = 0; i < mq.size(); i++) begin
        if (mq[i].v1 && mq[i].v2) begin iss = i; break; end
      end
      if (!issue_granted) iss = -1;
      if (cdb.cdb_valid) begin
        for (int i = 0; i < mq.size(); i++) begin
          if (!mq[i].v1 && mq[i].t1 == cdb.cdb_tag) begin mq[i].v1 = 1; mq[i].d1 = cdb.cdb_result; end
          if (!mq[i].v2 && mq[i].t2 == cdb.cdb_tag) begin mq[i].v2 = 1; mq[i].d2 = cdb.cdb_result; end
        end
      end
      if (iss >= 0) mq.delete(iss);
      if (dispatch_en && !full) begin
        e.tag = dispatch_rd_tag;
        e.d1 = dispatch_rs1_data; e.t1 = dispatch_rs1_tag; e.v1 = dispatch_rs1_valid;
        e.d2 = dispatch_rs2_data; e.t2 = dispatch_rs2_tag; e.v2 = dispatch_rs2_valid;
        if (cdb.cdb_valid && !e.v1 && e.t1 == cdb.cdb_tag) begin e.v1 = 1; e.d1 = cdb.cdb_result; end
        if (cdb.cdb_valid && !e.v2 && e.t2 == cdb.cdb_tag) begin e.v2 = 1; e.d2 = cdb.cdb_result; end
        mq.push_back(e);
      end
    end
  endtask

  task automatic push_expected();
    exp_t x;
    x.rdy = 0; x.data = '0;
    x.full = (mq.size() == DEPTH);
    x.empty = (mq.size() == 0);
    foreach (mq[i]) begin
      if (!x.rdy && mq[i].v1 && mq[i].v2) begin
        x.rdy = 1;
        x.data.rd_tag = TAG_W'(mq[i].tag);
        x.data.rs1_data = mq[i].d1;
        x.data.rs2_data = mq[i].d2;
      end
    end
    exp_q.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    push_expected();
  endtask

  // Monitor: compares the DUT against the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t x;
    #1;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      check("mult_ready", 128'(mult_ready), 128'(x.rdy));
      check("fifo_data", 128'(mult_exec_fifo_data), 128'(x.data));
      check("queue_full", 128'(queue_full), 128'(x.full));
      check("queue_empty", 128'(queue_empty), 128'(x.empty));
      $display("cycle t=%0t ready=%0d tag=%0d rs1=%0h rs2=%0h full=%0d empty=%0d", $time,
               mult_ready, mult_exec_fifo_data.rd_tag, mult_exec_fifo_data.rs1_data,
               mult_exec_fifo_data.rs2_data, queue_full, queue_empty);
    end
  end

  task automatic idle();
    rst = 0; flush = 0; dispatch_en = 0; issue_granted = 0;
    dispatch_rd_tag = '0; dispatch_rs1_tag = '0; dispatch_rs2_tag = '0;
    dispatch_rs1_data = '0; dispatch_rs2_data = '0;
    dispatch_rs1_valid = 0; dispatch_rs2_valid = 0;
    cdb = '0;
  endtask

  task automatic set_disp(input int tag, input logic [31:0] d1, input int t1, input bit v1,
                          input logic [31:0] d2, input int t2, input bit v2);
    dispatch_en = 1; dispatch_rd_tag = TAG_W'(tag);
    dispatch_rs1_data = d1; dispatch_rs1_tag = TAG_W'(t1); dispatch_rs1_valid = v1;
    dispatch_rs2_data = d2; dispatch_rs2_tag = TAG_W'(t2); dispatch_rs2_valid = v2;
  endtask

  task automatic set_cdb(input int tag, input logic [31:0] res);
    cdb.cdb_valid = 1; cdb.cdb_tag = TAG_W'(tag); cdb.cdb_result = res;
  endtask

  initial begin
    idle();
    rst = 1;
    tick(); tick();
    idle(); tick(); #2;
    check("reset_empty", 128'(queue_empty), 128'(1));
    check("reset_ready", 128'(mult_ready), 128'(0));
    check("reset_data", 128'(mult_exec_fifo_data), 128'(0));

    // Both operands ready at dispatch, then granted.
    set_disp(5, 3, 0, 1, 7, 0, 1); tick();
    idle(); issue_granted = 1; #2;
    check("basic_ready", 128'(mult_ready), 128'(1));
    check("basic_data", 128'(mult_exec_fifo_data), {58'd0, 6'd5, 32'd3, 32'd7});
    tick(); idle(); #2;
    check("basic_drained", 128'(queue_empty), 128'(1));

    // rs2 waits for tag 12 broadcast two cycles later.
    set_disp(8, 32'h1, 0, 1, 0, 12, 0); tick();
    idle(); tick();
    set_cdb(12, 32'h10); #2;
    check("wakeup_before", 128'(mult_ready), 128'(0));
    tick(); idle(); #2;
    check("wakeup_ready", 128'(mult_ready), 128'(1));
    check("wakeup_rs2", 128'(mult_exec_fifo_data.rs2_data), 128'(32'h10));
    issue_granted = 1; tick(); idle();

    // Same-cycle dispatch + broadcast bypass.
    set_disp(11, 0, 9, 0, 32'h4, 0, 1); set_cdb(9, 32'h22); tick();
    idle(); #2;
    check("bypass_ready", 128'(mult_ready), 128'(1));
    check("bypass_rs1", 128'(mult_exec_fifo_data.rs1_data), 128'(32'h22));
    issue_granted = 1; tick(); idle();

    // Fill, drop on full, out-of-order issue, order preserved.
    for (int t = 1; t <= 4; t++) begin
      if (t == 3) set_disp(t, 32'h33, 0, 1, 32'h44, 0, 1);
      else        set_disp(t, 0, 60, 0, 32'h5, 0, 1);
      tick();
    end
    idle(); #2;
    check("fill_full", 128'(queue_full), 128'(1));
    set_disp(6, 1, 0, 1, 2, 0, 1); tick(); idle(); #2;
    check("drop_sel", 128'(mult_exec_fifo_data.rd_tag), 128'(3));
    issue_granted = 1; tick(); idle(); #2;
    check("after_issue_full", 128'(queue_full), 128'(0));
    check("after_issue_ready", 128'(mult_ready), 128'(0));
    set_cdb(60, 32'h99); tick(); idle(); issue_granted = 1; #2;
    check("order_1", 128'(mult_exec_fifo_data.rd_tag), 128'(1));
    tick(); #2;
    check("order_2", 128'(mult_exec_fifo_data.rd_tag), 128'(2));
    tick(); #2;
    check("order_4", 128'(mult_exec_fifo_data.rd_tag), 128'(4));
    tick(); idle(); #2;
    check("order_empty", 128'(queue_empty), 128'(1));

    // Flush beats a same-cycle dispatch.
    for (int t = 20; t < 23; t++) begin set_disp(t, 0, 30, 0, 0, 31, 0); tick(); end
    idle(); flush = 1; set_disp(25, 1, 0, 1, 1, 0, 1); tick(); idle(); #2;
    check("flush_empty", 128'(queue_empty), 128'(1));
    check("flush_ready", 128'(mult_ready), 128'(0));

    // Randomized traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      idle();
      rst = ($urandom_range(0, 99) == 0);
      flush = ($urandom_range(0, 39) == 0);
      issue_granted = $urandom_range(0, 1);
      if ($urandom_range(0, 1) == 1)
        set_disp($urandom_range(0, 63), $urandom, $urandom_range(0, 7), $urandom_range(0, 1),
                 $urandom, $urandom_range(0, 7), $urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) set_cdb($urandom_range(0, 7), $urandom);
      tick();
    end
    idle();
    tick(); tick();
    #3;
    check("scoreboard_drained", 128'(exp_q.size()), 128'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
